// File: rtl/div_pkg.sv
// Shared definitions for the divider and its reverse-direction reconstruction checker.
package div_pkg;
  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } recon_state_t;
endpackage

// File: rtl/div_reconstruct_shift_add_step.sv
// One shift-add multiply step: conditionally adds the shifted multiplicand into the accumulator.
module shift_add_step #(
  parameter int WIDTH = 32,
  parameter int SHIFT_W = $clog2(WIDTH)
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic               mult_bit,
  input  logic [SHIFT_W-1:0] shift,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [2*WIDTH-1:0] addend;

  // Zero-extend before shifting so no multiplicand bits fall off the top.
  assign addend   = {{WIDTH{1'b0}}, multiplicand} << shift;
  assign acc_next = mult_bit ? (acc + addend) : acc;
endmodule

// File: rtl/div_reconstruct.sv
// Rebuilds dividend = quotient * divisor + remainder with a serial shift-add multiplier
// and flags overflow and remainder/divisor inconsistency.
module div_reconstruct
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] dividend,
  output logic             overflow,
  output logic             rem_err
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  recon_state_t       state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;
  logic               overflow_q, overflow_d;
  logic               rem_err_q, rem_err_d;

  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH:0]   sum;

  shift_add_step #(
    .WIDTH  (WIDTH),
    .SHIFT_W(CNT_W)
  ) u_step (
    .acc         (acc_q),
    .multiplicand(div_q),
    .mult_bit    (q_q[0]),
    .shift       (cnt_q),
    .acc_next    (step_acc)
  );

  // One extra bit keeps the carry out of acc + remainder for the overflow flag.
  assign sum = {1'b0, acc_q} + {{(WIDTH + 1){1'b0}}, rem_q};

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    div_d      = div_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ready_d    = 1'b0;
    dividend_d = dividend_q;
    overflow_d = overflow_q;
    rem_err_d  = rem_err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = quotient;
          div_d   = divisor;
          rem_d   = remainder;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = step_acc;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = FIN;
        end
      end
      FIN: begin
        dividend_d = sum[WIDTH-1:0];
        overflow_d = |sum[2*WIDTH:WIDTH];
        rem_err_d  = (rem_q >= div_q);
        ready_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      q_q        <= '0;
      div_q      <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      dividend_q <= '0;
      overflow_q <= 1'b0;
      rem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      dividend_q <= dividend_d;
      overflow_q <= overflow_d;
      rem_err_q  <= rem_err_d;
    end
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign dividend = dividend_q;
  assign overflow = overflow_q;
  assign rem_err  = rem_err_q;
endmodule

// File: tb/tb_div_reconstruct.sv
// Directed and randomized checks of the reconstruction multiplier against an arithmetic model.
module tb_div_reconstruct;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] quotient;
  logic [W-1:0] divisor;
  logic [W-1:0] remainder;
  logic         busy;
  logic         ready;
  logic [W-1:0] dividend;
  logic         overflow;
  logic         rem_err;

  int checks   = 0;
  int failures = 0;

  div_reconstruct #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .quotient (quotient),
    .divisor  (divisor),
    .remainder(remainder),
    .busy     (busy),
    .ready    (ready),
    .dividend (dividend),
    .overflow (overflow),
    .rem_err  (rem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact unsigned q*d + r with enough headroom for any operands.
  function automatic logic [2*W:0] ref_sum(input logic [W-1:0] q, input logic [W-1:0] d,
                                            input logic [W-1:0] r);
    logic [2*W:0] qq, dd, rr;
    qq = {{(W + 1){1'b0}}, q};
    dd = {{(W + 1){1'b0}}, d};
    rr = {{(W + 1){1'b0}}, r};
    return qq * dd + rr;
  endfunction

  task automatic launch(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r);
    start     = 1'b1;
    quotient  = q;
    divisor   = d;
    remainder = r;
  endtask

  // Consumes the accept edge, then waits for ready and checks result and latency.
  task automatic accept_and_wait(input logic [W-1:0] q, input logic [W-1:0] d,
                                 input logic [W-1:0] r, input bit disturb, input string tag);
    logic [2*W:0] full;
    int n;
    bit got;
    full = ref_sum(q, d, r);
    @(posedge clk);
    #1;
    start     = 1'b0;
    quotient  = $urandom;
    divisor   = $urandom;
    remainder = $urandom;
    chk({tag, "_busy_at_accept"}, 64'(busy), 64'd1);
    chk({tag, "_ready_low_at_accept"}, 64'(ready), 64'd0);
    n   = 0;
    got = 1'b0;
    while (!got && n < 80) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) got = 1'b1;
      else if (disturb) begin
        start     = 1'($urandom_range(0, 1));
        quotient  = $urandom;
        divisor   = $urandom;
        remainder = $urandom;
      end
    end
    start = 1'b0;
    chk({tag, "_ready_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(W + 1));
    chk({tag, "_dividend"}, 64'(dividend), 64'(full[W-1:0]));
    chk({tag, "_overflow"}, 64'(overflow), 64'(full > {{(W + 1){1'b0}}, {W{1'b1}}}));
    chk({tag, "_rem_err"}, 64'(rem_err), 64'(r >= d));
    chk({tag, "_busy_at_ready"}, 64'(busy), 64'd0);
    $display("op %s q=%0h d=%0h r=%0h -> dividend=%0h ovf=%0b rem_err=%0b cycles=%0d",
             tag, q, d, r, dividend, overflow, rem_err, n);
  endtask

  task automatic idle_hold(input logic [W-1:0] q, input logic [W-1:0] d,
                           input logic [W-1:0] r, input string tag);
    logic [2*W:0] full;
    full = ref_sum(q, d, r);
    @(posedge clk);
    #1;
    chk({tag, "_ready_one_cycle"}, 64'(ready), 64'd0);
    chk({tag, "_dividend_held"}, 64'(dividend), 64'(full[W-1:0]));
  endtask

  initial begin
    int ready_count;
    logic [W-1:0] rq, rd, rr;

    rst_n     = 1'b0;
    start     = 1'b0;
    quotient  = '0;
    divisor   = '0;
    remainder = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_dividend", 64'(dividend), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_rem_err", 64'(rem_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    launch(7, 4, 2);
    accept_and_wait(7, 4, 2, 1'b0, "basic");
    launch(4, 2, 1);
    accept_and_wait(4, 2, 1, 1'b0, "b2b");
    idle_hold(4, 2, 1, "b2b");

    @(negedge clk);
    launch(32'hFFFF_FFFF, 2, 0);
    accept_and_wait(32'hFFFF_FFFF, 2, 0, 1'b0, "ovf");
    @(negedge clk);
    launch(3, 0, 5);
    accept_and_wait(3, 0, 5, 1'b0, "div0");
    @(negedge clk);
    launch(5, 3, 4);
    accept_and_wait(5, 3, 4, 1'b1, "remerr_disturb");
    @(negedge clk);
    launch(0, 32'h1234_5678, 32'h99);
    accept_and_wait(0, 32'h1234_5678, 32'h99, 1'b0, "q0");

    for (int i = 0; i < 6; i++) begin
      rq = $urandom;
      rd = (i % 2 == 1) ? W'($urandom_range(0, 15)) : W'($urandom);
      rr = (i % 3 == 0) ? W'($urandom) : W'($urandom_range(0, 31));
      @(negedge clk);
      launch(rq, rd, rr);
      accept_and_wait(rq, rd, rr, (i % 2 == 1), $sformatf("rand%0d", i));
    end

    // Abort mid-operation: outputs from the previous result must clear immediately.
    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(ready), 64'd0);
    chk("abort_dividend", 64'(dividend), 64'd0);
    chk("abort_overflow", 64'(overflow), 64'd0);
    chk("abort_rem_err", 64'(rem_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ready_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready) ready_count++;
    end
    chk("abort_no_ready", 64'(ready_count), 64'd0);
    $display("op abort -> busy=%0b dividend=%0h ready_pulses=%0d", busy, dividend, ready_count);
    @(negedge clk);
    launch(11, 13, 6);
    accept_and_wait(11, 13, 6, 1'b0, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
